// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one-outstanding imem request/grant/response
// handshake feeding a one-entry valid/ready output register, with PC redirect
// on a controller jump and discard of any wrong-path prefetch.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 imem_req_o,
  output logic [ADDR_W-1:0]    imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [INSTR_W-1:0]   imem_rdata_i,
  output logic                 imem_rready_o,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [3:0]           opcode_o,
  output logic [INSTR_W-5:0]   operand_o,
  output logic [ADDR_W-1:0]    pc_o,
  input  logic                 en_jmp_i,
  input  logic [ADDR_W-1:0]    jmp_target_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_FULL_REQ, S_FULL_WAIT, S_FLUSH
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic                 valid_q, valid_d;
  logic [3:0]           opcode_q, opcode_d;
  logic [INSTR_W-5:0]   operand_q, operand_d;
  logic [ADDR_W-1:0]    pco_q, pco_d;

  logic                 handoff;
  logic [ADDR_W-1:0]    pc_inc;

  assign handoff = valid_q & instr_ready_i;
  assign pc_inc  = pc_q + ADDR_W'(1);

  // Handshake outputs decode straight from the state; address is always the PC.
  assign imem_req_o    = (state_q == S_REQ)  || (state_q == S_FULL_REQ);
  assign imem_rready_o = (state_q == S_WAIT) || (state_q == S_FLUSH);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign opcode_o      = opcode_q;
  assign operand_o     = operand_q;
  assign pc_o          = pco_q;

  // State register and datapath flops; reset abandons any outstanding fetch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      opcode_q   <= 4'b1111;
      operand_q  <= '0;
      pco_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      pco_q      <= pco_d;
    end
  end

  // Next-state logic: fetch sequencing, output-register load, jump redirect.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    valid_d    = valid_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    pco_d      = pco_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt_i) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_inc;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          opcode_d  = imem_rdata_i[INSTR_W-1 -: 4];
          operand_d = imem_rdata_i[INSTR_W-5:0];
          pco_d     = fetch_pc_q;
          valid_d   = 1'b1;
          state_d   = S_FULL_REQ;
        end
      end
      S_FULL_REQ: begin
        if (handoff) begin
          valid_d = 1'b0;
          if (en_jmp_i) begin
            // A fetch granted in the same cycle is on the wrong path.
            pc_d    = jmp_target_i;
            state_d = imem_gnt_i ? S_FLUSH : S_REQ;
          end else if (imem_gnt_i) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_inc;
            state_d    = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end else if (imem_gnt_i) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_inc;
          state_d    = S_FULL_WAIT;
        end
      end
      S_FULL_WAIT: begin
        // rready is low here, so memory keeps holding its response.
        if (handoff) begin
          valid_d = 1'b0;
          if (en_jmp_i) begin
            pc_d    = jmp_target_i;
            state_d = S_FLUSH;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_FLUSH: begin
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed phases push expected
// instructions; monitors pop and compare at every handoff.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // DUT 0: RESET_PC = 0
  logic        req0, gnt0, rvalid0, rready0, valid0, ready0, en_jmp0;
  logic [7:0]  addr0, pc0, operand0, target0;
  logic [11:0] rdata0;
  logic [3:0]  opcode0;
  logic        gnt_en, jmp_arm;

  // DUT 2: RESET_PC = 0xFE, sequential code only
  logic        req2, rvalid2, rready2, valid2, ready2;
  logic [7:0]  addr2, pc2, operand2;
  logic [11:0] rdata2;
  logic [3:0]  opcode2;

  logic [11:0] mem0 [256];
  logic [11:0] mem2 [256];
  logic        pend0, pend2;
  int          req_cnt = 0;
  logic [7:0]  last_addr;

  logic [19:0] q0[$];
  logic [19:0] q2[$];
  int          hs0 = 0, hs2 = 0;
  int          pass_cnt = 0, total_cnt = 0;

  assign gnt0    = gnt_en;
  assign rvalid0 = pend0;
  assign rvalid2 = pend2;
  // Controller model: opcode 4 is JMP to its operand.
  assign en_jmp0 = jmp_arm & valid0 & (opcode0 == 4'h4);
  assign target0 = operand0;

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(12), .RESET_PC(8'h00)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(req0), .imem_addr_o(addr0), .imem_gnt_i(gnt0),
    .imem_rvalid_i(rvalid0), .imem_rdata_i(rdata0), .imem_rready_o(rready0),
    .instr_valid_o(valid0), .instr_ready_i(ready0),
    .opcode_o(opcode0), .operand_o(operand0), .pc_o(pc0),
    .en_jmp_i(en_jmp0), .jmp_target_i(target0)
  );

  instr_fetch_unit #(.ADDR_W(8), .INSTR_W(12), .RESET_PC(8'hFE)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(1'b1),
    .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2), .imem_rready_o(rready2),
    .instr_valid_o(valid2), .instr_ready_i(ready2),
    .opcode_o(opcode2), .operand_o(operand2), .pc_o(pc2),
    .en_jmp_i(1'b0), .jmp_target_i(8'h00)
  );

  // 1-cycle memories: response held until rready, shared reset.
  always @(posedge clk) begin
    if (!rst_n) pend0 <= 1'b0;
    else begin
      if (rvalid0 && rready0) pend0 <= 1'b0;
      if (req0 && gnt0) begin
        pend0     <= 1'b1;
        rdata0    <= mem0[addr0];
        req_cnt   <= req_cnt + 1;
        last_addr <= addr0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) pend2 <= 1'b0;
    else begin
      if (rvalid2 && rready2) pend2 <= 1'b0;
      if (req2) begin
        pend2  <= 1'b1;
        rdata2 <= mem2[addr2];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm, input logic [31:0] act);
    total_cnt++;
    $display("FAIL %s: got 0x%0h expected nothing", nm, act);
  endtask

  // Monitors: every handoff pops one expected {opcode, operand, pc}.
  initial forever begin
    @(negedge clk);
    if (rst_n && valid0 && ready0) begin
      if (q0.size() == 0) fail_now("extra_instr0", {opcode0, operand0, pc0});
      else chk("instr0", {opcode0, operand0, pc0}, q0.pop_front());
      hs0++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && valid2 && ready2) begin
      if (q2.size() == 0) fail_now("extra_instr2", {opcode2, operand2, pc2});
      else chk("instr2", {opcode2, operand2, pc2}, q2.pop_front());
      hs2++;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; ready0 = 1'b0; ready2 = 1'b0; jmp_arm = 1'b0; gnt_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {valid0, req0, rready0, opcode0, operand0, pc0},
        {3'b000, 4'hF, 8'h00, 8'h00});
    q0.delete(); q2.delete(); hs0 = 0; hs2 = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string nm, input int max, output int cyc);
    cyc = 0;
    while (!valid0 && cyc < max) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!valid0) fail_now({nm, "_timeout"}, cyc);
  endtask

  task automatic wait_hs(input string nm, input int which, input int n, input int max);
    int c = 0;
    while (((which == 0) ? hs0 : hs2) < n && c < max) begin
      @(posedge clk); #1;
      c++;
    end
    if (((which == 0) ? hs0 : hs2) < n) fail_now({nm, "_timeout"}, c);
  endtask

  initial begin
    int cyc;
    int base;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 12'hF00;
      mem2[i] = 12'hF00;
    end
    mem0[8'h00] = 12'h101; mem0[8'h01] = 12'h805; mem0[8'h02] = 12'h440;
    mem0[8'h03] = 12'h333; mem0[8'h40] = 12'h2AA; mem0[8'h41] = 12'h3BB;
    mem2[8'hFE] = 12'h5FE; mem2[8'hFF] = 12'h6FF;
    mem2[8'h00] = 12'h700; mem2[8'h01] = 12'h801;

    // Phase A: first-fetch latency and in-order delivery
    do_reset();
    ready0 = 1'b1;
    q0.push_back(20'h1_01_00);
    q0.push_back(20'h8_05_01);
    @(posedge clk); #1;
    chk("first_req", {req0, addr0, valid0}, {1'b1, 8'h00, 1'b0});
    @(posedge clk); #1;
    chk("lat_cycle2", {31'd0, valid0}, 0);
    @(posedge clk); #1;
    chk("lat_cycle3", {31'd0, valid0}, 1);
    wait_hs("seqA", 0, 2, 20);
    ready0 = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("drainA", q0.size(), 0);

    // Phase B: stall with single prefetch, then jump from FULL_WAIT
    do_reset();
    jmp_arm = 1'b1;
    q0.push_back(20'h1_01_00);
    wait_valid("loadB", 10, cyc);
    base = req_cnt;
    repeat (6) begin
      @(posedge clk); #1;
      chk("hold", {valid0, rready0, opcode0, operand0, pc0}, {2'b10, 20'h1_01_00});
    end
    chk("prefetch_cnt", req_cnt - base, 1);
    chk("prefetch_addr", last_addr, 8'h01);
    q0.push_back(20'h8_05_01);
    q0.push_back(20'h4_40_02);
    q0.push_back(20'h2_AA_40);
    ready0 = 1'b1;
    wait_hs("seqB", 0, 2, 20);
    ready0 = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("full_wait_sig", {valid0, req0, rready0, pc0}, {3'b100, 8'h02});
    ready0 = 1'b1;
    @(posedge clk); #1;
    chk("flush_sig", {valid0, req0, rready0}, 3'b001);
    wait_valid("jmpB", 10, cyc);
    chk("jmp_lat_flush", cyc, 3);
    wait_hs("tgtB", 0, 4, 20);
    ready0 = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("drainB", q0.size(), 0);

    // Phase C: jump from FULL_REQ without a grant
    mem0[8'h00] = 12'h440;
    do_reset();
    jmp_arm = 1'b1;
    q0.push_back(20'h4_40_00);
    q0.push_back(20'h2_AA_40);
    wait_valid("loadC", 10, cyc);
    gnt_en = 1'b0;
    ready0 = 1'b1;
    @(posedge clk); #1;
    chk("redirect_addr", {req0, addr0, valid0}, {1'b1, 8'h40, 1'b0});
    gnt_en = 1'b1;
    wait_valid("jmpC", 10, cyc);
    chk("jmp_lat_req", cyc, 2);
    wait_hs("tgtC", 0, 2, 20);
    ready0 = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("drainC", q0.size(), 0);
    mem0[8'h00] = 12'h101;

    // Phase D: reset in FULL_WAIT abandons the fetch
    do_reset();
    q0.push_back(20'h1_01_00);
    wait_valid("loadD", 10, cyc);
    repeat (2) @(posedge clk); #1;
    chk("fw_before_rst", {valid0, req0, rready0}, 3'b100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid", {valid0, req0, rready0, opcode0, operand0, pc0},
        {3'b000, 4'hF, 8'h00, 8'h00});
    q0.delete(); hs0 = 0;
    q0.push_back(20'h1_01_00);
    rst_n = 1'b1;
    ready0 = 1'b1;
    @(posedge clk); #1;
    chk("rst_first_req", {req0, addr0}, {1'b1, 8'h00});
    wait_hs("seqD", 0, 1, 20);
    ready0 = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("drainD", q0.size(), 0);

    // Phase E: PC wrap from RESET_PC=0xFE
    do_reset();
    q2.push_back(20'h5_FE_FE);
    q2.push_back(20'h6_FF_FF);
    q2.push_back(20'h7_00_00);
    q2.push_back(20'h8_01_01);
    ready2 = 1'b1;
    wait_hs("wrapE", 2, 4, 40);
    ready2 = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("drainE", q2.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
